mem_access_ctrl: RTL and testbench

Load/store access controller in the MEM stage of the RISC-V core. It sits between the pipeline and a variable-latency data memory port, and converts a load or store into a single memory request with byte enables and lane-replicated write data. It stalls the pipeline until the access completes. For loads, it registers the returned word together with the byte offset and func3 that the downstream load-mask stage needs for lane select and sign/zero extension.

---
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage load/store access controller. Turns one load or store into a
//   single data-memory request (word address, byte enables, lane-replicated
//   write data), stalls the pipeline until the access completes, and for loads
//   registers the returned word plus the byte offset and func3 needed by the
//   downstream load-mask stage.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid         load/store present in MEM
//   req_is_store      1 = store, 0 = load
//   req_func3         RISC-V func3
//   req_addr          effective byte address
//   req_wdata         store data (rs2)
//   stall             freeze the pipeline this cycle (combinational)
//   err               one-cycle pulse for misaligned address / illegal func3
//   mem_req_valid     request to data memory
//   mem_req_ready     memory accepts the request
//   mem_addr          word-aligned request address
//   mem_we            byte write enables (0 for loads)
//   mem_wdata         lane-replicated store data
//   mem_resp_valid    load data valid
//   mem_resp_data     load data word
//   ld_valid          one-cycle pulse, ld_* fields valid
//   ld_data           raw returned word
//   ld_addr           byte offset of the completed load
//   ld_func3          func3 of the completed load
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_is_store,
  input  logic [2:0]       req_func3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic             ld_valid,
  output logic [WIDTH-1:0] ld_data,
  output logic [1:0]       ld_addr,
  output logic [2:0]       ld_func3
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic             r_is_store;
  logic [1:0]       r_off;
  logic [2:0]       r_func3;
  logic             r_err;
  logic [WIDTH-1:0] r_mem_addr;
  logic [3:0]       r_mem_we;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] r_ld_data;
  logic [1:0]       r_ld_addr;
  logic [2:0]       r_ld_func3;

  logic             w_legal;
  logic             w_accept;

  // func3[1:0] encodes the access size (byte/half/word); func3[2] is the
  // unsigned flag, which only exists for byte and halfword loads.
  function automatic logic f_legal(input logic       is_store,
                                   input logic [2:0] func3,
                                   input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (func3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    if (func3[2] && (is_store || func3[1]))
      ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [2:0] func3,
                                           input logic [1:0] off);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store data across all lanes so the memory only needs the
  // byte enables to pick the right bytes.
  function automatic logic [WIDTH-1:0] f_lane_data(input logic [2:0]       func3,
                                                   input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] d;
    case (func3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign w_legal  = f_legal(req_is_store, req_func3, req_addr[1:0]);
  assign w_accept = (r_state == S_IDLE) && req_valid && w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_store  <= 1'b0;
      r_off       <= 2'b00;
      r_func3     <= 3'b000;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 4'b0000;
      r_mem_wdata <= '0;
      r_ld_data   <= '0;
      r_ld_addr   <= 2'b00;
      r_ld_func3  <= 3'b000;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (!w_legal) begin
              r_err <= 1'b1;
            end else begin
              r_is_store  <= req_is_store;
              r_off       <= req_addr[1:0];
              r_func3     <= req_func3;
              r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              r_mem_we    <= req_is_store ? f_byte_en(req_func3, req_addr[1:0]) : 4'b0000;
              r_mem_wdata <= req_is_store ? f_lane_data(req_func3, req_wdata) : '0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready)
            r_state <= r_is_store ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_ld_data  <= mem_resp_data;
            r_ld_addr  <= r_off;
            r_ld_func3 <= r_func3;
            r_state    <= S_DONE;
          end
        end
        default: begin
          // DONE: the pipeline advances this cycle; any req_valid seen here is
          // the instruction just completed and must not be re-issued.
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall covers the accept cycle too, otherwise the instruction would leave
  // MEM before its access has even been issued.
  assign stall         = w_accept || (r_state == S_REQ) || (r_state == S_WAIT);
  assign err           = r_err;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_wdata     = r_mem_wdata;
  assign ld_valid      = (r_state == S_DONE) && !r_is_store;
  assign ld_data       = r_ld_data;
  assign ld_addr       = r_ld_addr;
  assign ld_func3      = r_ld_func3;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, err, mem_req_valid, ld_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [3:0]  mem_we;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic [1:0]  ld_addr;
  logic [2:0]  ld_func3;

  mem_access_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_addr(ld_addr), .ld_func3(ld_func3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected values for the current cycle (set just after the rising edge).
  logic        exp_stall = 0, exp_err = 0, exp_mreq = 0, exp_ldv = 0, exp_zero = 1;
  logic        err_pend = 0;
  logic        e_st = 0;
  logic [31:0] e_addr = 0, e_wd = 0;
  logic [3:0]  e_we = 0;
  logic [31:0] m_ld_data = 0;
  logic [1:0]  m_ld_addr = 0;
  logic [2:0]  m_ld_f3 = 0;

  // Observation counters kept by the compare process.
  int          hs_cnt = 0, ldv_cnt = 0, err_cnt = 0, stall_cnt = 0;
  logic [31:0] obs_addr = 0, obs_wd = 0;
  logic [3:0]  obs_we = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  // Access legality from the rules: size from func3[1:0], unsigned only for
  // byte/half loads, address must be a multiple of the access size.
  function automatic bit legal_f(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = int'(f3[1:0]);
    if (sz == 3) return 1'b0;
    if (f3[2] && (st || sz == 2)) return 1'b0;
    return (int'(a[1:0]) % (1 << sz)) == 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [31:0] a);
    int n, o;
    logic [3:0] m;
    n = 1 << int'(f3[1:0]);
    o = int'(a[1:0]);
    m = 4'b0000;
    for (int k = 0; k < 4; k++)
      if (k >= o && k < o + n) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] wd_f(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {24'h0, wd[7:0]} * 32'h01010101;
      2'b01:   return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("stall", stall, exp_stall);
    chk("err", err, exp_err);
    chk("mem_req_valid", mem_req_valid, exp_mreq);
    chk("ld_valid", ld_valid, exp_ldv);
    chk("ld_data", ld_data, m_ld_data);
    chk("ld_addr", ld_addr, m_ld_addr);
    chk("ld_func3", ld_func3, m_ld_f3);
    if (exp_zero) begin
      chk("mem_addr_rst", mem_addr, 32'h0);
      chk("mem_we_rst", mem_we, 4'h0);
      chk("mem_wdata_rst", mem_wdata, 32'h0);
    end else if (exp_mreq) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      if (e_st) chk("mem_wdata", mem_wdata, e_wd);
    end
    if (mem_req_valid && mem_req_ready) hs_cnt++;
    if (mem_req_valid) begin
      obs_addr = mem_addr;
      obs_we   = mem_we;
      obs_wd   = mem_wdata;
    end
    if (ld_valid) ldv_cnt++;
    if (err) err_cnt++;
    if (stall) stall_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_err  = err_pend;
    err_pend = 1'b0;
  endtask

  task automatic rand_req();
    req_valid    = 1'($urandom);
    req_is_store = 1'($urandom);
    req_func3    = 3'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rand_req();
      req_valid      = 1'b0;
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = 1'($urandom);
      mem_resp_data  = $urandom;
      exp_stall = 0; exp_mreq = 0; exp_ldv = 0;
    end
  endtask

  // One access from the accept cycle through DONE. rdel = cycles ready stays
  // low, ddel = WAIT cycles before the response.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdel, input int ddel,
                        input logic [31:0] rd, input bit hold);
    bit lg;
    lg = legal_f(st, f3, a);
    step();
    req_valid = 1; req_is_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    mem_req_ready  = 1'($urandom);
    mem_resp_valid = 1'($urandom);
    mem_resp_data  = $urandom;
    exp_stall = lg; exp_mreq = 0; exp_ldv = 0;
    if (!lg) begin
      err_pend = 1'b1;
      return;
    end
    exp_zero = 0;
    e_st   = st;
    e_addr = {a[31:2], 2'b00};
    e_we   = st ? be_f(f3, a) : 4'b0000;
    e_wd   = wd_f(f3, wd);
    for (int i = 0; i <= rdel; i++) begin
      step();
      if (i == 0) stall_cnt = 0;
      rand_req();
      mem_req_ready  = (i == rdel);
      mem_resp_valid = 1'($urandom);
      mem_resp_data  = $urandom;
      exp_stall = 1; exp_mreq = 1; exp_ldv = 0;
    end
    if (!st) begin
      for (int j = 0; j <= ddel; j++) begin
        step();
        rand_req();
        mem_req_ready  = 1'b0;
        mem_resp_valid = (j == ddel);
        mem_resp_data  = (j == ddel) ? rd : $urandom;
        exp_stall = 1; exp_mreq = 0; exp_ldv = 0;
      end
    end
    step();
    if (hold) begin
      req_valid = 1; req_is_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    end else begin
      req_valid = 0;
    end
    mem_req_ready  = 1'($urandom);
    mem_resp_valid = 1'($urandom);
    mem_resp_data  = $urandom;
    exp_stall = 0; exp_mreq = 0; exp_ldv = !st;
    if (!st) begin
      m_ld_data = rd;
      m_ld_addr = a[1:0];
      m_ld_f3   = f3;
    end
  endtask

  initial begin
    int hs0, ldv0, err0;
    // Reset state
    step();
    step();
    chk("reset_stall", stall, 1'b0);
    chk("reset_ld_data", ld_data, 32'h0);
    chk("reset_mem_we", mem_we, 4'h0);
    rst = 1'b0;
    idle(2);

    // LW, no wait states
    hs0 = hs_cnt; ldv0 = ldv_cnt;
    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    idle(1);
    chk("lw_ld_data", ld_data, 32'hDEADBEEF);
    chk("lw_ld_addr", ld_addr, 2'b00);
    chk("lw_ld_func3", ld_func3, 3'b010);
    chk("lw_mem_addr", obs_addr, 32'h100);
    chk("lw_mem_we", obs_we, 4'b0000);
    chk("lw_stall_cycles", stall_cnt, 2);
    chk("lw_requests", hs_cnt - hs0, 1);
    chk("lw_ld_pulses", ldv_cnt - ldv0, 1);

    // SB with backpressure
    ldv0 = ldv_cnt;
    access(1'b1, 3'b000, 32'h203, 32'h000000A5, 3, 0, 32'h0, 1'b0);
    idle(1);
    chk("sb_mem_we", obs_we, 4'b1000);
    chk("sb_mem_wdata", obs_wd, 32'hA5A5A5A5);
    chk("sb_stall_cycles", stall_cnt, 4);
    chk("sb_no_ld_valid", ldv_cnt - ldv0, 0);

    // Misaligned and illegal requests
    hs0 = hs_cnt; err0 = err_cnt;
    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0);
    access(1'b1, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
    access(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
    idle(2);
    chk("illegal_err_pulses", err_cnt - err0, 3);
    chk("illegal_no_request", hs_cnt - hs0, 0);

    // LHU, slow response
    hs0 = hs_cnt;
    access(1'b0, 3'b101, 32'h006, 32'h0, 0, 4, 32'h80010000, 1'b0);
    idle(2);
    chk("lhu_ld_addr", ld_addr, 2'b10);
    chk("lhu_ld_func3", ld_func3, 3'b101);
    chk("lhu_ld_data", ld_data, 32'h80010000);
    chk("lhu_requests", hs_cnt - hs0, 1);
    chk("lhu_stall_cycles", stall_cnt, 6);

    // Back-to-back SW then LB with req_valid held through DONE
    hs0 = hs_cnt;
    access(1'b1, 3'b010, 32'h300, 32'h11223344, 1, 0, 32'h0, 1'b1);
    access(1'b0, 3'b000, 32'h305, 32'h0, 0, 1, 32'hCAFEF00D, 1'b1);
    idle(2);
    chk("b2b_requests", hs_cnt - hs0, 2);
    chk("b2b_ld_data", ld_data, 32'hCAFEF00D);

    // Reset mid-access: LW reaches WAIT, then reset, then a late response
    ldv0 = ldv_cnt;
    step();
    req_valid = 1; req_is_store = 0; req_func3 = 3'b010; req_addr = 32'h40;
    mem_req_ready = 0; mem_resp_valid = 0;
    exp_stall = 1; exp_mreq = 0; exp_ldv = 0;
    exp_zero = 0; e_st = 0; e_addr = 32'h40; e_we = 4'b0000;
    step();
    req_valid = 0; mem_req_ready = 1;
    exp_stall = 1; exp_mreq = 1;
    step();
    mem_req_ready = 0;
    exp_stall = 1; exp_mreq = 0;
    rst = 1'b1;
    exp_stall = 0; exp_err = 0; err_pend = 0; exp_zero = 1;
    m_ld_data = 0; m_ld_addr = 0; m_ld_f3 = 0;
    step();
    step();
    rst = 1'b0;
    mem_resp_valid = 1; mem_resp_data = 32'h12345678;
    exp_stall = 0; exp_mreq = 0; exp_ldv = 0;
    step();
    mem_resp_valid = 0;
    idle(2);
    chk("rst_mid_ld_data", ld_data, 32'h0);
    chk("rst_mid_no_ld_valid", ldv_cnt - ldv0, 0);
    chk("rst_mid_stall", stall, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom) : 3'b010;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
      access(st, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
